// File: rtl/rx_intf_pkt_framer_mc.sv
`timescale 1ns / 1ps
// rx_intf_pkt_framer_mc
// Multi-source rx framer. It arbitrates N_SRC rx decoders at packet granularity
// (round robin), prepends a TSF word and a PHY-info word to each packet, and
// forwards the granted source's payload toward the m_axis master / S2MM DMA.
// It also applies the xpu filter verdict, recovers from a missing tlast by
// timeout, and raises a delayed rx_pkt_intr toward the PS.
//
// Build option: define RX_INTF_INTR_COALESCE_EN to coalesce DMA completion
// interrupts (count threshold coalesce_num or count_top timeout).
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   sig_valid/ht_unsupport    per-source SIGNAL-decoded pulse and its disqualifier
//   pkt_len/pkt_rate/rssi_half_db  per-source packet info, latched on grant
//   gpio_status               shared gpio status, latched on grant
//   data_in/data_in_valid     per-source payload words
//   block_rx_dma_to_ps(_valid) xpu filter verdict (1 = drop) and its strobe
//   m_axis_tlast, s2mm_intr   end-of-packet seen on m_axis, DMA completion
//   tsf_runtime_val, tsf_pulse_1M  running tsf and 1 us tick
//   recover_en, timeout_top   tlast-timeout recovery enable and limit (us)
//   count_top, coalesce_num   interrupt delay (cycles), packets per interrupt
//   data_out/data_out_valid   word stream to m_axis
//   start_trans, num_dma_symbol  DMA start pulse, words in packet incl. header
//   cur_src                   source granted for the current packet
//   m_axis_rst, tlast_auto_recover  m_axis flush, fake-tlast request
//   rx_pkt_sn_plus_one        pulse per accepted packet
//   drop_cnt                  saturating count of lost sig_valid events
//   rx_pkt_intr               interrupt pulse to PS
module rx_intf_pkt_framer_mc #(
   parameter int unsigned N_SRC        = 2,
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned TSF_W        = 64,
   parameter int unsigned SYM_W        = 14,
   parameter int unsigned TO_W         = 13,
   parameter int unsigned CNT_W        = 15,
   parameter int unsigned RST_HOLD_CYC = 8,
   localparam int unsigned SRC_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_SRC-1:0]        sig_valid,
   input  logic [N_SRC-1:0]        ht_unsupport,
   input  logic [N_SRC*16-1:0]     pkt_len,
   input  logic [N_SRC*8-1:0]      pkt_rate,
   input  logic [N_SRC*11-1:0]     rssi_half_db,
   input  logic [7:0]              gpio_status,
   input  logic [N_SRC*DATA_W-1:0] data_in,
   input  logic [N_SRC-1:0]        data_in_valid,
   input  logic                    block_rx_dma_to_ps,
   input  logic                    block_rx_dma_to_ps_valid,
   input  logic                    m_axis_tlast,
   input  logic                    s2mm_intr,
   input  logic [TSF_W-1:0]        tsf_runtime_val,
   input  logic                    tsf_pulse_1M,
   input  logic                    recover_en,
   input  logic [TO_W-1:0]         timeout_top,
   input  logic [CNT_W-1:0]        count_top,
   input  logic [3:0]              coalesce_num,
   output logic [DATA_W-1:0]       data_out,
   output logic                    data_out_valid,
   output logic                    start_trans,
   output logic [SYM_W-1:0]        num_dma_symbol,
   output logic [SRC_W-1:0]        cur_src,
   output logic                    m_axis_rst,
   output logic                    tlast_auto_recover,
   output logic                    rx_pkt_sn_plus_one,
   output logic [15:0]             drop_cnt,
   output logic                    rx_pkt_intr
);

   localparam int unsigned BPW    = DATA_W / 8;
   localparam int unsigned BPW_SH = $clog2(BPW);
   localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYC) + 1;

   typedef enum logic [2:0] {
      StIdle, StHdr0, StHdr1, StWaitFilter, StWaitTlast, StRstHold
   } state_e;

   state_e             state_q;
   logic [SRC_W-1:0]   rr_ptr_q;
   logic [TSF_W-1:0]   tsf_lock_q;
   logic [15:0]        len_q;
   logic [4:0]         rate_q;       // {rate[7], rate[3:0]}
   logic [10:0]        rssi_q;
   logic [7:0]         gpio_q;
   logic [TO_W-1:0]    to_q;
   logic [HOLD_W-1:0]  hold_q;

   // Per-source views of the flat input buses
   logic [DATA_W-1:0]  din_arr  [N_SRC];
   logic [15:0]        len_arr  [N_SRC];
   logic [4:0]         rate_arr [N_SRC];
   logic [10:0]        rssi_arr [N_SRC];

   for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
      assign din_arr[i]  = data_in[i*DATA_W +: DATA_W];
      assign len_arr[i]  = pkt_len[i*16 +: 16];
      assign rate_arr[i] = {pkt_rate[i*8+7], pkt_rate[i*8 +: 4]};
      assign rssi_arr[i] = rssi_half_db[i*11 +: 11];
   end

   // rate[6:4] is not carried in the header
   logic unused_rate_bits;
   assign unused_rate_bits = ^pkt_rate;

   // Round-robin grant: first qualified source at or after rr_ptr
   logic [N_SRC-1:0]  q;
   logic              gnt_found;
   logic [SRC_W-1:0]  gnt_idx;
   int unsigned       rot;

   always_comb begin
      q         = sig_valid & ~ht_unsupport;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      rot       = 0;
      for (int k = 0; k < N_SRC; k++) begin
         rot = (32'(rr_ptr_q) + 32'(k)) % N_SRC;
         if (!gnt_found && q[rot[SRC_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = rot[SRC_W-1:0];
         end
      end
   end

   // Every qualified event except the one granted in IDLE is a drop
   logic [2:0]  q_cnt;
   logic [2:0]  drop_inc;
   logic [16:0] drop_sum;
   logic [15:0] drop_nxt;

   always_comb begin
      q_cnt = 3'($countones(q));
      if (state_q == StIdle) drop_inc = gnt_found ? (q_cnt - 3'd1) : 3'd0;
      else                   drop_inc = q_cnt;
      drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);
      drop_nxt = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   // Packet length in words, plus the two header words
   logic [16:0]       len_words;
   logic [SYM_W-1:0]  sym_nxt;
   assign len_words = ({1'b0, len_arr[gnt_idx]} + 17'(BPW - 1)) >> BPW_SH;
   assign sym_nxt   = SYM_W'(len_words + 17'd2);

   logic [52:0] hdr1_word;
   assign hdr1_word = {rate_q, len_q, 8'd0, gpio_q, 5'd0, rssi_q};

   logic timed_out;
   assign timed_out = recover_en && (to_q > timeout_top);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q            <= StIdle;
         rr_ptr_q           <= '0;
         tsf_lock_q         <= '0;
         len_q              <= '0;
         rate_q             <= '0;
         rssi_q             <= '0;
         gpio_q             <= '0;
         to_q               <= '0;
         hold_q             <= '0;
         data_out           <= '0;
         data_out_valid     <= 1'b0;
         start_trans        <= 1'b0;
         num_dma_symbol     <= '0;
         cur_src            <= '0;
         m_axis_rst         <= 1'b0;
         tlast_auto_recover <= 1'b0;
         rx_pkt_sn_plus_one <= 1'b0;
         drop_cnt           <= '0;
      end else begin
         start_trans        <= 1'b0;
         rx_pkt_sn_plus_one <= 1'b0;
         tlast_auto_recover <= 1'b0;
         drop_cnt           <= drop_nxt;
         if (|q) tsf_lock_q <= tsf_runtime_val;

         // Timeout ticks only while waiting on the filter or tlast
         if ((state_q == StWaitFilter || state_q == StWaitTlast) &&
             tsf_pulse_1M && (to_q != '1)) begin
            to_q <= to_q + TO_W'(1);
         end

         case (state_q)
            StIdle: begin
               data_out       <= '0;
               data_out_valid <= 1'b0;
               if (gnt_found) begin
                  cur_src        <= gnt_idx;
                  rr_ptr_q       <= (gnt_idx == SRC_W'(N_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
                  len_q          <= len_arr[gnt_idx];
                  rate_q         <= rate_arr[gnt_idx];
                  rssi_q         <= rssi_arr[gnt_idx];
                  gpio_q         <= gpio_status;
                  num_dma_symbol <= sym_nxt;
                  to_q           <= '0;
                  state_q        <= StHdr0;
               end
            end
            StHdr0: begin
               data_out       <= DATA_W'(tsf_lock_q);
               data_out_valid <= 1'b1;
               state_q        <= StHdr1;
            end
            StHdr1: begin
               data_out       <= DATA_W'(hdr1_word);
               data_out_valid <= 1'b1;
               state_q        <= StWaitFilter;
            end
            StWaitFilter, StWaitTlast: begin
               // Timeout outranks both the verdict and tlast
               if (timed_out) begin
                  tlast_auto_recover <= 1'b1;
                  m_axis_rst         <= 1'b1;
                  data_out           <= '0;
                  data_out_valid     <= 1'b0;
                  num_dma_symbol     <= '0;
                  hold_q             <= '0;
                  state_q            <= StRstHold;
               end else if (state_q == StWaitFilter && block_rx_dma_to_ps_valid &&
                            block_rx_dma_to_ps) begin
                  m_axis_rst     <= 1'b1;
                  data_out       <= '0;
                  data_out_valid <= 1'b0;
                  num_dma_symbol <= '0;
                  hold_q         <= '0;
                  state_q        <= StRstHold;
               end else if (state_q == StWaitTlast && m_axis_tlast) begin
                  data_out       <= '0;
                  data_out_valid <= 1'b0;
                  state_q        <= StIdle;
               end else begin
                  data_out       <= din_arr[cur_src];
                  data_out_valid <= data_in_valid[cur_src];
                  if (state_q == StWaitFilter && block_rx_dma_to_ps_valid) begin
                     start_trans        <= 1'b1;
                     rx_pkt_sn_plus_one <= 1'b1;
                     to_q               <= '0;
                     state_q            <= StWaitTlast;
                  end
               end
            end
            StRstHold: begin
               data_out       <= '0;
               data_out_valid <= 1'b0;
               num_dma_symbol <= '0;
               if (hold_q == HOLD_W'(RST_HOLD_CYC - 1)) begin
                  m_axis_rst <= 1'b0;
                  state_q    <= StIdle;
               end else begin
                  hold_q <= hold_q + HOLD_W'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Interrupt generation
   logic [CNT_W-1:0] icnt_q;

`ifdef RX_INTF_INTR_COALESCE_EN
   logic [4:0] pend_q;
   logic [4:0] pend_sum;
   logic [4:0] thr;
   logic       fire_to;
   logic       fire_num;

   always_comb begin
      thr      = (coalesce_num == 4'd0) ? 5'd1 : {1'b0, coalesce_num};
      pend_sum = pend_q + 5'(s2mm_intr);
      fire_to  = (pend_q != 5'd0) && (icnt_q == count_top);
      fire_num = s2mm_intr && (pend_sum >= thr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q      <= '0;
         icnt_q      <= '0;
         rx_pkt_intr <= 1'b0;
      end else begin
         rx_pkt_intr <= 1'b0;
         if (fire_to) begin
            // A coincident completion opens the next batch
            rx_pkt_intr <= 1'b1;
            pend_q      <= 5'(s2mm_intr);
            icnt_q      <= '0;
         end else if (fire_num) begin
            rx_pkt_intr <= 1'b1;
            pend_q      <= '0;
            icnt_q      <= '0;
         end else if (pend_q != 5'd0) begin
            pend_q <= pend_sum;
            icnt_q <= icnt_q + CNT_W'(1);
         end else if (s2mm_intr) begin
            pend_q <= 5'd1;
            icnt_q <= '0;
         end
      end
   end
`else
   logic armed_q;
   logic unused_coalesce;
   assign unused_coalesce = ^coalesce_num;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed_q     <= 1'b0;
         icnt_q      <= '0;
         rx_pkt_intr <= 1'b0;
      end else begin
         rx_pkt_intr <= 1'b0;
         if (armed_q) begin
            // Completions while armed ride on the pending pulse
            if (icnt_q == count_top) begin
               rx_pkt_intr <= 1'b1;
               armed_q     <= 1'b0;
            end else begin
               icnt_q <= icnt_q + CNT_W'(1);
            end
         end else if (s2mm_intr) begin
            armed_q <= 1'b1;
            icnt_q  <= '0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_rx_intf_pkt_framer_mc.sv
`timescale 1ns / 1ps
// Directed bench for rx_intf_pkt_framer_mc (default build, N_SRC = 2).
module tb_rx_intf_pkt_framer_mc;

   logic          clk;
   logic          rst;
   logic [1:0]    sig_valid;
   logic [1:0]    ht_unsupport;
   logic [31:0]   pkt_len;
   logic [15:0]   pkt_rate;
   logic [21:0]   rssi_half_db;
   logic [7:0]    gpio_status;
   logic [127:0]  data_in;
   logic [1:0]    data_in_valid;
   logic          block_rx_dma_to_ps;
   logic          block_rx_dma_to_ps_valid;
   logic          m_axis_tlast;
   logic          s2mm_intr;
   logic [63:0]   tsf_runtime_val;
   logic          tsf_pulse_1M;
   logic          recover_en;
   logic [12:0]   timeout_top;
   logic [14:0]   count_top;
   logic [3:0]    coalesce_num;
   logic [63:0]   data_out;
   logic          data_out_valid;
   logic          start_trans;
   logic [13:0]   num_dma_symbol;
   logic [0:0]    cur_src;
   logic          m_axis_rst;
   logic          tlast_auto_recover;
   logic          rx_pkt_sn_plus_one;
   logic [15:0]   drop_cnt;
   logic          rx_pkt_intr;

   int n_vec  = 0;
   int n_miss = 0;

   rx_intf_pkt_framer_mc dut (
      .clk                      (clk),
      .rst                      (rst),
      .sig_valid                (sig_valid),
      .ht_unsupport             (ht_unsupport),
      .pkt_len                  (pkt_len),
      .pkt_rate                 (pkt_rate),
      .rssi_half_db             (rssi_half_db),
      .gpio_status              (gpio_status),
      .data_in                  (data_in),
      .data_in_valid            (data_in_valid),
      .block_rx_dma_to_ps       (block_rx_dma_to_ps),
      .block_rx_dma_to_ps_valid (block_rx_dma_to_ps_valid),
      .m_axis_tlast             (m_axis_tlast),
      .s2mm_intr                (s2mm_intr),
      .tsf_runtime_val          (tsf_runtime_val),
      .tsf_pulse_1M             (tsf_pulse_1M),
      .recover_en               (recover_en),
      .timeout_top              (timeout_top),
      .count_top                (count_top),
      .coalesce_num             (coalesce_num),
      .data_out                 (data_out),
      .data_out_valid           (data_out_valid),
      .start_trans              (start_trans),
      .num_dma_symbol           (num_dma_symbol),
      .cur_src                  (cur_src),
      .m_axis_rst               (m_axis_rst),
      .tlast_auto_recover       (tlast_auto_recover),
      .rx_pkt_sn_plus_one       (rx_pkt_sn_plus_one),
      .drop_cnt                 (drop_cnt),
      .rx_pkt_intr              (rx_pkt_intr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle past the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int hi_cycles;
   int seen_start;
   int first_intr;
   int n_intr;

   initial begin
      rst = 1'b1;
      sig_valid = '0; ht_unsupport = '0; pkt_len = '0; pkt_rate = '0;
      rssi_half_db = '0; gpio_status = '0; data_in = '0; data_in_valid = '0;
      block_rx_dma_to_ps = 1'b0; block_rx_dma_to_ps_valid = 1'b0;
      m_axis_tlast = 1'b0; s2mm_intr = 1'b0; tsf_runtime_val = 64'h0;
      tsf_pulse_1M = 1'b0; recover_en = 1'b0; timeout_top = 13'd10;
      count_top = 15'd20; coalesce_num = 4'd0;
      repeat (3) step();

      // Reset state
      check_val("rst_data_out", data_out, 0);
      check_val("rst_valid", data_out_valid, 0);
      check_val("rst_start", start_trans, 0);
      check_val("rst_num_sym", num_dma_symbol, 0);
      check_val("rst_cur_src", cur_src, 0);
      check_val("rst_maxis_rst", m_axis_rst, 0);
      check_val("rst_recover", tlast_auto_recover, 0);
      check_val("rst_sn", rx_pkt_sn_plus_one, 0);
      check_val("rst_drop", drop_cnt, 0);
      check_val("rst_intr", rx_pkt_intr, 0);
      rst = 1'b0;
      step();

      // Dual event with rr_ptr = 0: src0 wins, src1 dropped; src0 len 40 -> 5 + 2 words
      sig_valid = 2'b11;
      pkt_len   = {16'd8, 16'd40};
      step();
      sig_valid = 2'b00;
      check_val("dual1_cur_src", cur_src, 0);
      check_val("dual1_drop", drop_cnt, 1);
      check_val("dual1_num_sym", num_dma_symbol, 7);
      step();
      step();

      // Block verdict: flush held exactly 8 cycles, no start / sn
      block_rx_dma_to_ps_valid = 1'b1;
      block_rx_dma_to_ps       = 1'b1;
      step();
      block_rx_dma_to_ps_valid = 1'b0;
      block_rx_dma_to_ps       = 1'b0;
      check_val("blk_maxis_rst", m_axis_rst, 1);
      check_val("blk_num_sym", num_dma_symbol, 0);
      check_val("blk_valid", data_out_valid, 0);
      hi_cycles  = 1;
      seen_start = int'(start_trans | rx_pkt_sn_plus_one);
      for (int i = 0; i < 20; i++) begin
         step();
         seen_start |= int'(start_trans | rx_pkt_sn_plus_one);
         if (m_axis_rst) hi_cycles++;
         else break;
      end
      check_val("blk_rst_cycles", hi_cycles, 8);
      check_val("blk_no_start_sn", seen_start, 0);

      // Second dual event: pointer moved to src1; len 8 -> 1 + 2 words
      sig_valid = 2'b11;
      step();
      sig_valid = 2'b00;
      check_val("dual2_cur_src", cur_src, 1);
      check_val("dual2_drop", drop_cnt, 2);
      check_val("dual2_num_sym", num_dma_symbol, 3);
      recover_en = 1'b1;
      step();
      step();

      // Event while busy is dropped
      sig_valid = 2'b01;
      step();
      sig_valid = 2'b00;
      check_val("busy_drop", drop_cnt, 3);

      // Timeout: 10 ticks not enough, 11th trips it and outranks a pass verdict
      for (int i = 0; i < 10; i++) begin
         tsf_pulse_1M = 1'b1;
         step();
         tsf_pulse_1M = 1'b0;
         step();
      end
      check_val("to10_recover", tlast_auto_recover, 0);
      check_val("to10_maxis_rst", m_axis_rst, 0);
      tsf_pulse_1M = 1'b1;
      step();
      tsf_pulse_1M = 1'b0;
      block_rx_dma_to_ps_valid = 1'b1;
      step();
      block_rx_dma_to_ps_valid = 1'b0;
      check_val("to11_recover", tlast_auto_recover, 1);
      check_val("to11_maxis_rst", m_axis_rst, 1);
      check_val("to11_no_start", start_trans, 0);
      check_val("to11_no_sn", rx_pkt_sn_plus_one, 0);
      step();
      check_val("to_recover_pulse", tlast_auto_recover, 0);
      repeat (10) step();
      recover_en = 1'b0;
      check_val("to_hold_done", m_axis_rst, 0);

      // Unsupported-HT event is not qualified
      sig_valid    = 2'b10;
      ht_unsupport = 2'b10;
      step();
      sig_valid    = 2'b00;
      ht_unsupport = 2'b00;
      step();
      check_val("ht_valid", data_out_valid, 0);
      check_val("ht_drop", drop_cnt, 3);

      // Single src0 packet, len 100 -> 13 + 2 words, pass verdict, tlast
      tsf_runtime_val = 64'h1122_3344_5566_7788;
      sig_valid       = 2'b01;
      pkt_len         = {16'd0, 16'd100};
      pkt_rate        = {8'h00, 8'h8B};
      rssi_half_db    = {11'd0, 11'h123};
      gpio_status     = 8'h5A;
      step();
      sig_valid       = 2'b00;
      tsf_runtime_val = 64'hFFFF_0000_FFFF_0000;
      check_val("pkt_num_sym", num_dma_symbol, 15);
      check_val("pkt_cur_src", cur_src, 0);
      check_val("pkt_grant_valid", data_out_valid, 0);
      step();
      check_val("hdr0_data", data_out, 64'h1122_3344_5566_7788);
      check_val("hdr0_valid", data_out_valid, 1);
      step();
      check_val("hdr1_data", data_out, 64'h001B_0064_005A_0123);
      data_in       = {64'h0, 64'hDEAD_BEEF_0000_0001};
      data_in_valid = 2'b01;
      step();
      check_val("pay_data", data_out, 64'hDEAD_BEEF_0000_0001);
      check_val("pay_valid", data_out_valid, 1);
      check_val("pay_no_start", start_trans, 0);
      block_rx_dma_to_ps_valid = 1'b1;
      step();
      block_rx_dma_to_ps_valid = 1'b0;
      check_val("pass_start", start_trans, 1);
      check_val("pass_sn", rx_pkt_sn_plus_one, 1);
      step();
      check_val("pass_start_once", start_trans, 0);
      check_val("tlast_pre_valid", data_out_valid, 1);
      m_axis_tlast = 1'b1;
      step();
      m_axis_tlast  = 1'b0;
      data_in_valid = 2'b00;
      check_val("tlast_valid", data_out_valid, 0);
      step();
      check_val("idle_valid", data_out_valid, 0);
      check_val("idle_num_sym", num_dma_symbol, 15);

      // Delayed interrupt: completions at t and t+5 give one pulse at t+21
      s2mm_intr = 1'b1;
      step();
      s2mm_intr  = 1'b0;
      first_intr = -1;
      n_intr     = 0;
      for (int k = 1; k <= 30; k++) begin
         s2mm_intr = (k == 5);
         step();
         if (rx_pkt_intr) begin
            n_intr++;
            if (first_intr < 0) first_intr = k;
         end
      end
      s2mm_intr = 1'b0;
      check_val("intr_time", first_intr, 21);
      check_val("intr_count", n_intr, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
